// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: one-hot digit rotation, frame-synchronous
// double-buffered updates, per-digit enable/blink and 16-level PWM brightness.
module seg_scan_driver #(
  parameter int NUM_DIGITS      = 6,
  parameter int SEG_W           = 8,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLINK_FRAMES    = 250,
  parameter bit SEL_ACTIVE_LOW  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_bus,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic [3:0]                  bright,
  input  logic                        load,
  output logic                        busy,
  output logic                        upd_done,
  output logic [NUM_DIGITS-1:0]       sel,
  output logic [SEG_W-1:0]            seg,
  output logic                        frame_tick
);

  localparam int SUB_TICKS = TICKS_PER_DIGIT / 16;
  localparam int CNT_W     = $clog2(TICKS_PER_DIGIT);
  localparam int SUBT_W    = $clog2(SUB_TICKS);
  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam int FR_W      = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [SUBT_W-1:0] SUBT_LAST = SUBT_W'(SUB_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FR_W-1:0]   FR_LAST   = FR_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]  cnt;
  logic [SUBT_W-1:0] sub_tick;
  logic [3:0]        sub;
  logic [IDX_W-1:0]  idx;
  logic [FR_W-1:0]   frame_cnt;
  logic              blink_phase;
  logic              slot_end;

  logic [NUM_DIGITS*SEG_W-1:0] stg_seg, act_seg;
  logic [NUM_DIGITS-1:0]       stg_en, act_en;
  logic [NUM_DIGITS-1:0]       stg_blink, act_blink;
  logic [3:0]                  stg_bright, act_bright;

  logic                  lit;
  logic [NUM_DIGITS-1:0] onehot;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_tick = slot_end && (idx == IDX_LAST);

  // sub is derived by a prescaler instead of dividing cnt
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      sub_tick    <= '0;
      sub         <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt      <= '0;
        sub_tick <= '0;
        sub      <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        if (sub_tick == SUBT_LAST) begin
          sub_tick <= '0;
          sub      <= sub + 1'b1;
        end else begin
          sub_tick <= sub_tick + 1'b1;
        end
      end
      if (frame_tick) begin
        if (frame_cnt == FR_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // A load coinciding with the apply lands in staging after the old copy moves over
  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_seg    <= '1;
      act_seg    <= '1;
      stg_en     <= '0;
      act_en     <= '0;
      stg_blink  <= '0;
      act_blink  <= '0;
      stg_bright <= 4'hF;
      act_bright <= 4'hF;
      busy       <= 1'b0;
      upd_done   <= 1'b0;
    end else begin
      upd_done <= frame_tick && busy;
      if (frame_tick && busy) begin
        act_seg    <= stg_seg;
        act_en     <= stg_en;
        act_blink  <= stg_blink;
        act_bright <= stg_bright;
        busy       <= 1'b0;
      end
      if (load) begin
        stg_seg    <= seg_bus;
        stg_en     <= digit_en;
        stg_blink  <= blink_mask;
        stg_bright <= bright;
        busy       <= 1'b1;
      end
    end
  end

  always_comb begin
    lit    = act_en[idx] && (sub <= act_bright) && !(blink_phase && act_blink[idx]);
    onehot = '0;
    if (lit) onehot[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
      seg <= '1;
    end else begin
      sel <= onehot ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
      seg <= lit ? act_seg[idx*SEG_W +: SEG_W] : '1;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised time-multiplexed 7-segment scan driver for the clock display. Drives NUM_DIGITS common-select lines one-hot in rotation from a flat segment bus. Adds frame-synchronous double-buffered updates, a per-digit enable mask, per-digit blink and 16-level PWM brightness. Sits between the time/digit encoders and the board select/segment pins.

Parameters:
NUM_DIGITS, 6, number of digits scanned (2..8)
SEG_W, 8, segment bits per digit (segments active-low, bit 7 = DP)
TICKS_PER_DIGIT, 50000, clk cycles per digit slot; multiple of 16, >=32
BLINK_FRAMES, 250, full scan frames per blink half-period (>=1)
SEL_ACTIVE_LOW, 0, 1 = select lines active-low

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
seg_bus  in  NUM_DIGITS*SEG_W  digit d pattern at [d*SEG_W +: SEG_W]; digit 0 scanned first
digit_en  in  NUM_DIGITS  1 = digit shown, 0 = forced blank
blink_mask  in  NUM_DIGITS  1 = digit blinks
bright  in  4  brightness 0 (1/16 duty) .. 15 (full duty)
load  in  1  1-cycle strobe: capture seg_bus/digit_en/blink_mask/bright into staging
busy  out  1  staging holds an update not yet applied
upd_done  out  1  1-cycle pulse: staging copied to active set
sel  out  NUM_DIGITS  one-hot digit select (polarity per SEL_ACTIVE_LOW)
seg  out  SEG_W  segment pattern for selected digit
frame_tick  out  1  1-cycle pulse at the last cycle of each full scan frame

Behaviour:
- Reset (clk edge with rst=0): cnt=0, sub=0, idx=0, blink_phase=0, frame counter=0, busy=0, upd_done=0, frame_tick=0; active and staging seg=all-ones, en=0, blink=0, bright=15; sel=all inactive (0, or all-ones if SEL_ACTIVE_LOW); seg=all-ones. Display stays blank until the first update applies.
- Slot counter cnt: 0..TICKS_PER_DIGIT-1, +1 per clk, wraps to 0. Sub-slot sub = cnt / (TICKS_PER_DIGIT/16), 0..15, kept as a separate counter (no divider).
- idx advances on cnt==TICKS_PER_DIGIT-1; wraps NUM_DIGITS-1 -> 0.
- frame_tick=1 in the cycle where idx==NUM_DIGITS-1 and cnt==TICKS_PER_DIGIT-1, else 0. It is combinational from the counters, with no added latency.
- load: staging <= inputs, busy <= 1. A second load before apply overwrites staging; the latest wins.
- Apply: on a frame_tick cycle with busy=1, active <= staging, busy <= 0, upd_done=1 next cycle. If load and frame_tick coincide, the apply uses the old staging and the new load is captured, leaving busy=1 for the next frame. Active values change only at frame boundaries, so there is no mid-frame tearing.
- Blink: frame counter increments on frame_tick. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- lit = en_act[idx] & (sub <= bright_act) & ~(blink_phase & blink_act[idx]).
- Outputs are registered, 1-cycle latency from counter state. If lit: sel = one-hot bit idx, seg = seg_act[idx]. Else: sel all inactive, seg all-ones.
- SEL_ACTIVE_LOW inverts sel only; seg polarity is fixed.
- Reset mid-frame returns to the reset state on the next edge, and any pending update is discarded.

Test Plan:
- Params ND=4, TPD=32, BF=2. Reset, load seg_bus={8'h99,8'hB0,8'hA4,8'hF9}, en=4'hF, bright=15 -> sel/seg all-inactive/ff until first frame end; upd_done pulses one cycle after frame_tick. Then sel=0001 with seg F9 for 32 cycles, 0010/A4, 0100/B0, 1000/99, and wrap.
- bright=3 -> each slot lit exactly 8 of 32 cycles (sub 0..3, 2 cycles each), blank for the remaining 24 cycles.
- digit_en=4'b1011 -> in slot 2, sel=0000 and seg=ff for all 32 cycles; the other slots are unaffected.
- blink_mask=4'b0001 -> digit 0 shown in frames 0-1, blanked in frames 2-3, repeating; digits 1-3 remain steady.
- Apply rules: two loads within one frame -> only the second pattern is displayed. A load on the frame_tick cycle while busy -> previous staging applies now, the new pattern applies at the next frame end, and busy stays high through the intervening frame.
- SEL_ACTIVE_LOW=1 -> sel=1110 for digit 0 and 1111 when blank. Assert rst mid-slot -> next cycle shows reset values and busy=0.
